// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 defaults), counter/address types and output bundle.
package vga_timing_pkg;

   localparam int unsigned DEF_H_SYNC = 96;
   localparam int unsigned DEF_H_BP   = 48;
   localparam int unsigned DEF_H_ACT  = 640;
   localparam int unsigned DEF_H_FP   = 16;
   localparam int unsigned DEF_V_SYNC = 2;
   localparam int unsigned DEF_V_BP   = 33;
   localparam int unsigned DEF_V_ACT  = 480;
   localparam int unsigned DEF_V_FP   = 10;

   localparam int unsigned H_TOT   = DEF_H_SYNC + DEF_H_BP + DEF_H_ACT + DEF_H_FP;
   localparam int unsigned V_TOT   = DEF_V_SYNC + DEF_V_BP + DEF_V_ACT + DEF_V_FP;
   localparam int unsigned H_START = DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned V_START = DEF_V_SYNC + DEF_V_BP;

   localparam int unsigned CNT_W  = 11;
   localparam int unsigned ADDR_W = 10;

   typedef logic [CNT_W-1:0]  cnt_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef struct packed {
      logic  hs;
      logic  vs;
      logic  blank_n;
      logic  line_start;
      logic  frame_start;
      addr_t h_addr;
      addr_t v_addr;
   } vga_out_t;

   localparam vga_out_t OUT_RST = '{
      hs:          1'b1,
      vs:          1'b1,
      blank_n:     1'b0,
      line_start:  1'b0,
      frame_start: 1'b0,
      h_addr:      '0,
      v_addr:      '0
   };

   // Half-open window test: lo <= val < hi.
   function automatic logic in_window(input cnt_t val, input cnt_t lo, input cnt_t hi);
      return (val >= lo) && (val < hi);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter 0..MAX with enable, combinational terminal count and async active-high reset.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned MAX = 799
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tc_o
);

   localparam cnt_t MAX_C = cnt_t'(MAX);

   cnt_t cnt_d, cnt_q;

   assign tc_o  = (cnt_q == MAX_C);
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + cnt_t'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blank/address generator: two chained axis counters plus a registered decode stage.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_SYNC = DEF_H_SYNC,
   parameter int unsigned H_BP   = DEF_H_BP,
   parameter int unsigned H_ACT  = DEF_H_ACT,
   parameter int unsigned H_FP   = DEF_H_FP,
   parameter int unsigned V_SYNC = DEF_V_SYNC,
   parameter int unsigned V_BP   = DEF_V_BP,
   parameter int unsigned V_ACT  = DEF_V_ACT,
   parameter int unsigned V_FP   = DEF_V_FP
) (
   input  logic        iCLK,
   input  logic        iRST,
   output logic [9:0]  oH_ADDR,
   output logic [9:0]  oV_ADDR,
   output logic        oHS,
   output logic        oVS,
   output logic        oBLANK_n,
   output logic        oLINE_START,
   output logic        oFRAME_START
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

   localparam cnt_t H_SYNC_C      = cnt_t'(H_SYNC);
   localparam cnt_t V_SYNC_C      = cnt_t'(V_SYNC);
   localparam cnt_t H_ACT_START   = cnt_t'(H_SYNC + H_BP);
   localparam cnt_t H_ACT_END     = cnt_t'(H_SYNC + H_BP + H_ACT);
   localparam cnt_t V_ACT_START   = cnt_t'(V_SYNC + V_BP);
   localparam cnt_t V_ACT_END     = cnt_t'(V_SYNC + V_BP + V_ACT);

   cnt_t     h_cnt, v_cnt;
   logic     h_tc, v_tc;
   logic     h_act, v_act, active;
   logic     at_origin_d, at_origin_q;
   vga_out_t out_d, out_q;

   vga_axis_counter #(
      .MAX (H_TOTAL - 1)
   ) u_h_cnt (
      .clk_i (iCLK),
      .rst_i (iRST),
      .en_i  (1'b1),
      .cnt_o (h_cnt),
      .tc_o  (h_tc)
   );

   // Vertical advances only on the horizontal wrap cycle.
   vga_axis_counter #(
      .MAX (V_TOTAL - 1)
   ) u_v_cnt (
      .clk_i (iCLK),
      .rst_i (iRST),
      .en_i  (h_tc),
      .cnt_o (v_cnt),
      .tc_o  (v_tc)
   );

   assign h_act       = in_window(h_cnt, H_ACT_START, H_ACT_END);
   assign v_act       = in_window(v_cnt, V_ACT_START, V_ACT_END);
   assign active      = h_act & v_act;
   // Counters sit at (0,0) in the cycle after both terminal counts, and straight out of reset.
   assign at_origin_d = h_tc & v_tc;

   always_comb begin
      out_d             = OUT_RST;
      out_d.hs          = ~(h_cnt < H_SYNC_C);
      out_d.vs          = ~(v_cnt < V_SYNC_C);
      out_d.blank_n     = active;
      out_d.line_start  = active && (h_cnt == H_ACT_START);
      out_d.frame_start = at_origin_q;
      if (active) begin
         out_d.h_addr = addr_t'(h_cnt - H_ACT_START);
         out_d.v_addr = addr_t'(v_cnt - V_ACT_START);
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         out_q       <= OUT_RST;
         at_origin_q <= 1'b1;
      end else begin
         out_q       <= out_d;
         at_origin_q <= at_origin_d;
      end
   end

   assign oHS          = out_q.hs;
   assign oVS          = out_q.vs;
   assign oBLANK_n     = out_q.blank_n;
   assign oLINE_START  = out_q.line_start;
   assign oFRAME_START = out_q.frame_start;
   assign oH_ADDR      = out_q.h_addr;
   assign oV_ADDR      = out_q.v_addr;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Checks a small-timing and a default-timing instance against a time-based reference model.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   typedef struct {
      int hsync, hbp, hact, hfp, vsync, vbp, vact, vfp;
   } tim_t;

   localparam int S_HS = 5, S_HBP = 4, S_HACT = 16, S_HFP = 3;
   localparam int S_VS = 2, S_VBP = 3, S_VACT = 6,  S_VFP = 2;
   localparam int S_HT = S_HS + S_HBP + S_HACT + S_HFP;
   localparam int S_VT = S_VS + S_VBP + S_VACT + S_VFP;
   localparam int S_FR = S_HT * S_VT;

   localparam logic [24:0] RST_BUS = {1'b1, 1'b1, 23'd0};

   tim_t ps = '{S_HS, S_HBP, S_HACT, S_HFP, S_VS, S_VBP, S_VACT, S_VFP};
   tim_t pd = '{DEF_H_SYNC, DEF_H_BP, DEF_H_ACT, DEF_H_FP,
                DEF_V_SYNC, DEF_V_BP, DEF_V_ACT, DEF_V_FP};

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [9:0] s_ha, s_va, d_ha, d_va;
   logic s_hs, s_vs, s_blank, s_ls, s_fs;
   logic d_hs, d_vs, d_blank, d_ls, d_fs;
   logic [24:0] s_bus, d_bus;

   assign s_bus = {s_hs, s_vs, s_blank, s_ls, s_fs, s_ha, s_va};
   assign d_bus = {d_hs, d_vs, d_blank, d_ls, d_fs, d_ha, d_va};

   vga_timing_gen #(
      .H_SYNC (S_HS), .H_BP (S_HBP), .H_ACT (S_HACT), .H_FP (S_HFP),
      .V_SYNC (S_VS), .V_BP (S_VBP), .V_ACT (S_VACT), .V_FP (S_VFP)
   ) u_dut_s (
      .iCLK         (clk),
      .iRST         (rst),
      .oH_ADDR      (s_ha),
      .oV_ADDR      (s_va),
      .oHS          (s_hs),
      .oVS          (s_vs),
      .oBLANK_n     (s_blank),
      .oLINE_START  (s_ls),
      .oFRAME_START (s_fs)
   );

   vga_timing_gen u_dut_d (
      .iCLK         (clk),
      .iRST         (rst),
      .oH_ADDR      (d_ha),
      .oV_ADDR      (d_va),
      .oHS          (d_hs),
      .oVS          (d_vs),
      .oBLANK_n     (d_blank),
      .oLINE_START  (d_ls),
      .oFRAME_START (d_fs)
   );

   always #5 clk = ~clk;

   // Rising edges seen since reset was last released.
   int k;
   always @(posedge clk or posedge rst) begin
      if (rst) k <= 0;
      else     k <= k + 1;
   end

   int n_total = 0;
   int n_bad   = 0;
   int phase   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
      end
   endtask

   // Output after edge kk decodes position (kk-1) of a free-running raster.
   function automatic logic [24:0] model(input int kk, input tim_t p);
      int c, h, v, ht, vt, hst, vst;
      logic act;
      logic [9:0] ha, va;
      if (kk == 0) return RST_BUS;
      ht  = p.hsync + p.hbp + p.hact + p.hfp;
      vt  = p.vsync + p.vbp + p.vact + p.vfp;
      hst = p.hsync + p.hbp;
      vst = p.vsync + p.vbp;
      c   = kk - 1;
      h   = c % ht;
      v   = (c / ht) % vt;
      act = (h >= hst) && (h < hst + p.hact) && (v >= vst) && (v < vst + p.vact);
      ha  = act ? 10'(h - hst) : 10'd0;
      va  = act ? 10'(v - vst) : 10'd0;
      return {(h >= p.hsync), (v >= p.vsync), act, act && (h == hst), (h == 0) && (v == 0),
              ha, va};
   endfunction

   int s_hs_lo = 0, s_vs_lo = 0, s_fs_n = 0, s_ls_n = 0, s_ha_chg = 0;
   int d_hs_lo = 0, d_blank_n = 0, d_blank_first = 0;
   logic       s_blank_prev = 1'b0;
   logic [9:0] s_ha_prev = '0;
   int line0_k;

   initial line0_k = V_START * H_TOT;

   always @(negedge clk) begin
      check("small_out", {7'd0, s_bus}, {7'd0, model(k, ps)});
      check("dflt_out", {7'd0, d_bus}, {7'd0, model(k, pd)});
      if (phase == 1) begin
         if (k >= 1 && k <= S_FR) begin
            s_hs_lo += int'(!s_hs);
            s_vs_lo += int'(!s_vs);
            s_fs_n  += int'(s_fs);
            s_ls_n  += int'(s_ls);
            if (s_blank && s_blank_prev && s_ha != s_ha_prev) s_ha_chg++;
         end
         if (k >= 1 && k <= H_TOT) d_hs_lo += int'(!d_hs);
         if (k > line0_k && k <= line0_k + H_TOT) begin
            d_blank_n += int'(d_blank);
            if (d_blank && d_blank_first == 0) d_blank_first = k - line0_k;
         end
      end
      s_blank_prev = s_blank;
      s_ha_prev    = s_ha;
   end

   task automatic pulse_reset(input int hold);
      @(posedge clk);
      #($urandom_range(1, 3));
      rst = 1'b1;
      #1;
      check("async_s", {7'd0, s_bus}, {7'd0, RST_BUS});
      check("async_d", {7'd0, d_bus}, {7'd0, RST_BUS});
      repeat (hold) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("restart_s", {29'd0, s_hs, s_vs, s_fs}, 32'b001);
      check("restart_d", {29'd0, d_hs, d_vs, d_fs}, 32'b001);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_s", {7'd0, s_bus}, {7'd0, RST_BUS});
      check("rst_d", {7'd0, d_bus}, {7'd0, RST_BUS});
      rst   = 1'b0;
      phase = 1;
      @(negedge clk);
      check("first_s", {29'd0, s_hs, s_vs, s_fs}, 32'b001);
      check("first_d", {29'd0, d_hs, d_vs, d_fs}, 32'b001);
      repeat (line0_k + H_TOT + 200) @(negedge clk);
      phase = 0;

      check("s_hs_low",    s_hs_lo,  S_HS * S_VT);
      check("s_vs_low",    s_vs_lo,  S_VS * S_HT);
      check("s_frame_n",   s_fs_n,   1);
      check("s_line_n",    s_ls_n,   S_VACT);
      check("s_addr_chg",  s_ha_chg, (S_HACT - 1) * S_VACT);
      check("d_hs_low",    d_hs_lo,  DEF_H_SYNC);
      check("d_blank_len", d_blank_n, DEF_H_ACT);
      check("d_blank_1st", d_blank_first, H_START + 1);

      // Mid-frame reset on the small raster: counters at line 5, column 12.
      pulse_reset(1);
      repeat (5 * S_HT + 12 - 2) @(posedge clk);
      pulse_reset(3);

      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(1, 900)) @(negedge clk);
         pulse_reset($urandom_range(1, 3));
      end
      repeat (2 * S_FR + 50) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
